// File: rtl/mat2x2_pkg.sv
// Shared definitions for the 2x2 matrix-multiplier stream driver.
package mat2x2_pkg;

  localparam int unsigned DEFAULT_DW = 4;

  // Legacy state encodings, kept so existing debug tooling still decodes the state register.
  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_SEND  = 2'd3;

  typedef enum logic [1:0] {
    S_LOAD  = ST_LOAD,
    S_START = ST_START,
    S_WAIT  = ST_WAIT,
    S_SEND  = ST_SEND
  } state_e;

  // Operand element order on the input stream.
  localparam int unsigned IDX_A00 = 0;
  localparam int unsigned IDX_A01 = 1;
  localparam int unsigned IDX_A10 = 2;
  localparam int unsigned IDX_A11 = 3;
  localparam int unsigned IDX_B00 = 4;
  localparam int unsigned IDX_B01 = 5;
  localparam int unsigned IDX_B10 = 6;
  localparam int unsigned IDX_B11 = 7;

  // Result element order on the output stream.
  localparam int unsigned IDX_C00 = 0;
  localparam int unsigned IDX_C01 = 1;
  localparam int unsigned IDX_C10 = 2;
  localparam int unsigned IDX_C11 = 3;

endpackage

// File: rtl/mat2x2_result_serializer.sv
// Captures the four multiplier results and replays them on a valid/ready stream.
module mat2x2_result_serializer
  import mat2x2_pkg::*;
#(
  parameter int unsigned DW = DEFAULT_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture_i,
  input  logic [2*DW-1:0] c00_i,
  input  logic [2*DW-1:0] c01_i,
  input  logic [2*DW-1:0] c10_i,
  input  logic [2*DW-1:0] c11_i,
  input  logic            active_i,
  output logic            m_valid_o,
  output logic [2*DW-1:0] m_data_o,
  input  logic            m_ready_i,
  output logic            last_o
);

  logic [2*DW-1:0] c_q [4];
  logic [1:0]      idx_q;
  logic            hs;

  // Output mux; data only advances on a handshake, so it holds while stalled.
  always_comb begin
    m_valid_o = active_i;
    m_data_o  = c_q[idx_q];
    hs        = active_i && m_ready_i;
    last_o    = hs && (idx_q == 2'(IDX_C11));
  end

  // Capture results on done, then step the read index per accepted word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) c_q[i] <= '0;
      idx_q <= '0;
    end else if (capture_i) begin
      c_q[IDX_C00] <= c00_i;
      c_q[IDX_C01] <= c01_i;
      c_q[IDX_C10] <= c10_i;
      c_q[IDX_C11] <= c11_i;
      idx_q        <= '0;
    end else if (hs) begin
      idx_q <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/mat2x2_stream_driver.sv
// Host-side initiator for the 2x2 start/done matrix multiplier core.
module mat2x2_stream_driver
  import mat2x2_pkg::*;
#(
  parameter int unsigned DW      = DEFAULT_DW,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  input  logic [DW-1:0]   s_data,
  output logic            s_ready,
  output logic [DW-1:0]   mm_A00,
  output logic [DW-1:0]   mm_A01,
  output logic [DW-1:0]   mm_A10,
  output logic [DW-1:0]   mm_A11,
  output logic [DW-1:0]   mm_B00,
  output logic [DW-1:0]   mm_B01,
  output logic [DW-1:0]   mm_B10,
  output logic [DW-1:0]   mm_B11,
  output logic            mm_start,
  input  logic [2*DW-1:0] mm_C00,
  input  logic [2*DW-1:0] mm_C01,
  input  logic [2*DW-1:0] mm_C10,
  input  logic [2*DW-1:0] mm_C11,
  input  logic            mm_done,
  output logic            m_valid,
  output logic [2*DW-1:0] m_data,
  input  logic            m_ready,
  output logic            err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CW-1:0]   ctr_q, ctr_d;
  logic            err_q, err_d;
  logic [DW-1:0]   op_q [8];
  logic            load_en;
  logic            capture;
  logic            ser_last;

  assign mm_A00 = op_q[IDX_A00];
  assign mm_A01 = op_q[IDX_A01];
  assign mm_A10 = op_q[IDX_A10];
  assign mm_A11 = op_q[IDX_A11];
  assign mm_B00 = op_q[IDX_B00];
  assign mm_B01 = op_q[IDX_B01];
  assign mm_B10 = op_q[IDX_B10];
  assign mm_B11 = op_q[IDX_B11];
  assign err    = err_q;

  // Handshake outputs decode from state; s_ready is also gated off while reset is asserted.
  always_comb begin
    s_ready  = rst && (state_q == S_LOAD);
    mm_start = (state_q == S_START);
  end

  // Next-state logic: load 8 operands, start, wait with timeout, send 4 results.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ctr_d   = ctr_q;
    err_d   = err_q;
    load_en = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (s_valid) begin
          load_en = 1'b1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(IDX_B11)) state_d = S_START;
        end
      end
      S_START: begin
        ctr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done is checked first so it wins over a coincident timeout
        if (mm_done) begin
          capture = 1'b1;
          state_d = S_SEND;
        end else if (ctr_q == CW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_LOAD;
        end else begin
          ctr_d = ctr_q + CW'(1);
        end
      end
      S_SEND: begin
        if (ser_last) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State, operand and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
      ctr_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) op_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ctr_q   <= ctr_d;
      err_q   <= err_d;
      if (load_en) op_q[idx_q] <= s_data;
    end
  end

  mat2x2_result_serializer #(
    .DW(DW)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .capture_i (capture),
    .c00_i     (mm_C00),
    .c01_i     (mm_C01),
    .c10_i     (mm_C10),
    .c11_i     (mm_C11),
    .active_i  (state_q == S_SEND),
    .m_valid_o (m_valid),
    .m_data_o  (m_data),
    .m_ready_i (m_ready),
    .last_o    (ser_last)
  );

endmodule

// File: tb/tb_mat2x2_stream_driver.sv
// Self-checking bench for mat2x2_stream_driver with a behavioural multiplier core.
module tb_mat2x2_stream_driver;

  localparam int unsigned DW = 4;
  localparam int unsigned TO = 31;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [DW-1:0] mm_A00, mm_A01, mm_A10, mm_A11, mm_B00, mm_B01, mm_B10, mm_B11;
  logic          mm_start;
  logic [7:0]    core_c00 = '0, core_c01 = '0, core_c10 = '0, core_c11 = '0;
  logic [7:0]    mm_C00, mm_C01, mm_C10, mm_C11;
  logic          core_done = 1'b0, inj_done = 1'b0;
  logic          mm_done;
  logic          m_valid;
  logic [7:0]    m_data;
  logic          m_ready = 1'b0;
  logic          err;

  assign mm_done = core_done | inj_done;
  assign mm_C00  = inj_done ? 8'hEE : core_c00;
  assign mm_C01  = inj_done ? 8'hEE : core_c01;
  assign mm_C10  = inj_done ? 8'hEE : core_c10;
  assign mm_C11  = inj_done ? 8'hEE : core_c11;

  always #5 clk = ~clk;

  mat2x2_stream_driver #(.DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mm_A00(mm_A00), .mm_A01(mm_A01), .mm_A10(mm_A10), .mm_A11(mm_A11),
    .mm_B00(mm_B00), .mm_B01(mm_B01), .mm_B10(mm_B10), .mm_B11(mm_B11),
    .mm_start(mm_start),
    .mm_C00(mm_C00), .mm_C01(mm_C01), .mm_C10(mm_C10), .mm_C11(mm_C11),
    .mm_done(mm_done), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .err(err)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] c_of(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c, input logic [3:0] d);
    logic [7:0] r;
    r = {4'b0, a} * {4'b0, b} + {4'b0, c} * {4'b0, d};
    return r;
  endfunction

  // Reference core: responds core_lat cycles after a start, product taken from held operands.
  int unsigned core_lat = 3;
  bit          core_en = 1'b1;
  bit          start_seen = 1'b0;
  int unsigned core_cnt = 0;
  always @(posedge clk) begin
    #2;
    core_done = 1'b0;
    if (!rst) core_cnt = 0;
    else begin
      if (start_seen && core_en) core_cnt = core_lat;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_done = 1'b1;
          core_c00 = c_of(mm_A00, mm_B00, mm_A01, mm_B10);
          core_c01 = c_of(mm_A00, mm_B01, mm_A01, mm_B11);
          core_c10 = c_of(mm_A10, mm_B00, mm_A11, mm_B10);
          core_c11 = c_of(mm_A10, mm_B01, mm_A11, mm_B11);
        end
      end
    end
  end

  // Downstream ready pattern: 0 always ready, 1 ready one cycle in four, 2 never ready.
  int unsigned mr_mode = 0;
  int unsigned mr_cnt = 0;
  always @(posedge clk) begin
    #1;
    mr_cnt++;
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (mr_cnt % 4 == 0);
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor / scoreboard at the falling edge.
  logic [7:0]  exp_q[$];
  int unsigned n_in = 0, n_out = 0, n_start = 0;
  bit          excl_viol = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  always @(negedge clk) begin
    start_seen = rst && mm_start;
    if (rst) begin
      if (mm_start) n_start++;
      if (s_valid && s_ready) n_in++;
      if (s_ready && m_valid) excl_viol = 1'b1;
      if (prev_stall && m_valid) check_eq("stall_hold", 32'(m_data), 32'(prev_data));
      if (m_valid && m_ready) begin
        n_out++;
        check_eq("queue_has_exp", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("result", 32'(m_data), 32'(exp_q.pop_front()));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] e[8]);
    exp_q.push_back(c_of(e[0], e[4], e[1], e[6]));
    exp_q.push_back(c_of(e[0], e[5], e[1], e[7]));
    exp_q.push_back(c_of(e[2], e[4], e[3], e[6]));
    exp_q.push_back(c_of(e[2], e[5], e[3], e[7]));
  endtask

  task automatic stream(input logic [3:0] e[8], input bit gaps);
    for (int i = 0; i < 8; i++) begin
      bit          hs;
      int unsigned g;
      if (gaps) begin
        s_valid = 1'b0;
        tick();
      end
      s_valid = 1'b1;
      s_data  = e[i];
      hs = 1'b0;
      g  = 0;
      while (!hs && g < 200) begin
        @(negedge clk);
        hs = s_ready;
        tick();
        g++;
      end
      if (!hs) begin
        check_eq("load_timeout", 32'(s_ready), 32'd1);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_out(input int unsigned target);
    int unsigned g = 0;
    while (n_out < target && g < 400) begin
      tick();
      g++;
    end
    if (n_out < target) check_eq("out_timeout", n_out, target);
    check_eq("q_drained", exp_q.size(), 32'd0);
  endtask

  task automatic reset_pulse_and_check(input string tag);
    rst = 1'b0;
    @(negedge clk);
    check_eq({tag, "_s_ready_in_rst"}, 32'(s_ready), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_eq({tag, "_A00"},     32'(mm_A00), 32'd0);
    check_eq({tag, "_B11"},     32'(mm_B11), 32'd0);
    check_eq({tag, "_start"},   32'(mm_start), 32'd0);
    check_eq({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check_eq({tag, "_m_data"},  32'(m_data), 32'd0);
    check_eq({tag, "_err"},     32'(err), 32'd0);
    check_eq({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    exp_q.delete();
    tick();
  endtask

  initial begin
    logic [3:0]  e[8];
    int unsigned b_in, b_out, b_start, d;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_start",   32'(mm_start), 32'd0);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_data",  32'(m_data), 32'd0);
    check_eq("rst_err",     32'(err), 32'd0);
    check_eq("rst_A00",     32'(mm_A00), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_eq("load_s_ready", 32'(s_ready), 32'd1);
    tick();

    // 1: known product, back-to-back, always ready
    mr_mode = 0;
    e = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    exp_q.push_back(8'd19); exp_q.push_back(8'd22);
    exp_q.push_back(8'd43); exp_q.push_back(8'd50);
    b_start = n_start; b_out = n_out;
    stream(e, 1'b0);
    @(negedge clk);
    check_eq("t1_start_latency", 32'(mm_start), 32'd1);
    tick();
    wait_out(b_out + 4);
    check_eq("t1_one_start", n_start - b_start, 32'd1);

    // 2: all 15 -> 450 wraps to 0xC2 in the core
    e = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    repeat (4) exp_q.push_back(8'hC2);
    b_out = n_out;
    stream(e, 1'b0);
    wait_out(b_out + 4);
    check_eq("t2_err", 32'(err), 32'd0);

    // 3: gapped input, stalled output
    mr_mode = 1;
    e = '{4'd9, 4'd3, 4'd14, 4'd7, 4'd2, 4'd11, 4'd5, 4'd13};
    push_exp(e);
    b_in = n_in; b_out = n_out; b_start = n_start;
    stream(e, 1'b1);
    wait_out(b_out + 4);
    check_eq("t3_in_hs",  n_in - b_in, 32'd8);
    check_eq("t3_out_hs", n_out - b_out, 32'd4);
    check_eq("t3_starts", n_start - b_start, 32'd1);
    mr_mode = 0;

    // 4: no done -> timeout after TO+1 WAIT cycles following the start cycle
    core_en = 1'b0;
    e = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    stream(e, 1'b0);
    @(negedge clk);
    check_eq("t4_start", 32'(mm_start), 32'd1);
    d = 0;
    while (!err && d < 100) begin
      @(negedge clk);
      d++;
    end
    check_eq("t4_err_latency", d, TO + 2);
    check_eq("t4_back_in_load", 32'(s_ready), 32'd1);
    check_eq("t4_no_valid", 32'(m_valid), 32'd0);
    tick();
    core_en = 1'b1;
    e = '{4'd2, 4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    push_exp(e);
    b_out = n_out;
    stream(e, 1'b0);
    wait_out(b_out + 4);
    check_eq("t4_err_sticky", 32'(err), 32'd1);

    // 5: stray done in LOAD and in SEND is ignored
    b_start = n_start;
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    @(negedge clk);
    check_eq("t5_load_state", 32'(s_ready), 32'd1);
    check_eq("t5_load_valid", 32'(m_valid), 32'd0);
    tick();
    mr_mode = 2;
    e = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    push_exp(e);
    b_out = n_out;
    stream(e, 1'b0);
    d = 0;
    while (d < 100) begin
      @(negedge clk);
      d++;
      if (m_valid) break;
    end
    check_eq("t5_reach_send", 32'(m_valid), 32'd1);
    tick();
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    @(negedge clk);
    check_eq("t5_send_valid", 32'(m_valid), 32'd1);
    check_eq("t5_send_data", 32'(m_data), 32'(c_of(4'd7, 4'd3, 4'd6, 4'd1)));
    tick();
    mr_mode = 0;
    wait_out(b_out + 4);
    check_eq("t5_starts", n_start - b_start, 32'd1);

    // 6a: reset in WAIT
    core_lat = 10;
    e = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
    push_exp(e);
    stream(e, 1'b0);
    tick();
    tick();
    reset_pulse_and_check("t6_wait");
    core_lat = 3;

    // 6b: reset mid-SEND after two words
    mr_mode = 1;
    e = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
    push_exp(e);
    b_out = n_out;
    stream(e, 1'b0);
    d = 0;
    while (n_out < b_out + 2 && d < 200) begin
      tick();
      d++;
    end
    check_eq("t6_two_words", n_out - b_out, 32'd2);
    reset_pulse_and_check("t6_send");
    mr_mode = 0;

    // 6c: clean transaction after reset
    e = '{4'd12, 4'd1, 4'd0, 4'd9, 4'd3, 4'd15, 4'd8, 4'd2};
    push_exp(e);
    b_out = n_out;
    stream(e, 1'b0);
    wait_out(b_out + 4);
    check_eq("t6_err_clear", 32'(err), 32'd0);

    check_eq("ready_valid_exclusive", 32'(excl_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
